mdio_phy_responder: RTL and testbench
=====================================

// Module: mdio_phy_responder
// PURPOSE
// - PHY-side (responder) end of the Ethernet MDIO management interface (eth_mdc_o/eth_md_o/eth_md_oe/eth_md_i).
// - Decodes IEEE 802.3 Clause-22 frames from the MAC-side station and serves a 16-bit register file.
// - Used in FPGA/emulation builds where no real PHY management plane exists, and as a bus-functional peer.
// PARAMETERS
// - PreambleLen  32  number of consecutive 1s required before ST (1..32)
// - NumRegs      32  implemented registers, addr 0..NumRegs-1 (1..32)
// - RegResetVal  '0  logic [NumRegs-1:0][15:0] reset contents of the register file
// - SyncStages   2   flops synchronising mdc_i/mdio_i into clk_i (>=2)
// PORTS
// - clk_i       in   1   system clock; must be >= 4x MDC frequency
// - rst_i       in   1   synchronous, active-high reset
// - phy_addr_i  in   5   this responder's PHY address (quasi-static)
// - mdc_i       in   1   MDC from station (asynchronous to clk_i)
// - mdio_i      in   1   MDIO from pad (asynchronous to clk_i)
// - mdio_o      out  1   MDIO drive value
// - mdio_oe_o   out  1   MDIO drive enable (1 = responder drives)
// - busy_o      out  1   frame in progress (state != IDLE)
// - wr_valid_o  out  1   1-cycle pulse: register write committed
// - wr_addr_o   out  5   address of committed write
// - wr_data_o   out  16  data of committed write
// BEHAVIOUR
// - Reset: mdio_o=1, mdio_oe_o=0, busy_o=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, regs=RegResetVal, state=IDLE, pre_cnt=0.
// - "Edge" = rising edge detected on synchronised MDC (sync_q & ~sync_qq); all sampling/driving occurs only on edges.
// - Data sampled at an edge is the synchronised mdio_i at that clk_i cycle; outputs change in the same cycle (register stage only).
// - Frame bit index k after preamble: ST 0-1, OP 2-3, PHYAD 4-8, REGAD 9-13, TA 14-15, DATA 16-31 (MSB first).
// - IDLE: edge with 1 -> pre_cnt++ (saturates at PreambleLen); edge with 0 -> if pre_cnt==PreambleLen go HDR (k=0 consumed), else pre_cnt=0.
// - HDR (k=1..13): k=1 must be 1 else -> IDLE, pre_cnt=0. OP 10=read, 01=write; 00/11 -> IDLE after k=3.
//   At k=8, PHYAD!=phy_addr_i -> SKIP. At k=13 latch regad; read: shadow = (regad<NumRegs) ? reg[regad] : 16'hFFFF.
// - TA read: at edge k=14 set mdio_oe_o=1, mdio_o=0 (TA bit 2). Write: TA bits ignored, never drive.
// - RDATA: at edge k=15..30 drive mdio_o = shadow[30-k] (k=15 -> bit15); at edge k=31 mdio_oe_o=0, mdio_o=1 -> IDLE.
// - WDATA: shift in bits at k=16..31; at k=31, if regad<NumRegs: reg[regad]<=data, wr_valid_o=1 next cycle for 1 clk_i, wr_addr_o/wr_data_o updated and held until next commit; else no pulse.
// - SKIP: count edges to k=31 without driving, then IDLE.
// - After any frame end/abort: IDLE with pre_cnt=0 (no preamble suppression).
// - Read shadow frozen at k=13: concurrent state changes do not affect an in-flight read.
// - mdio_oe_o is 1 only in TA(read)/RDATA; never asserted when PHYAD mismatches.
// - rst_i mid-frame: all outputs return to reset values the cycle after rst_i is sampled; partial write discarded.
// - MDC stopped mid-frame: state held indefinitely (no timeout).
// TESTING
// - Reset, RegResetVal[2]=16'h0141: 32x1, read phyad=phy_addr_i=5'h01 reg 2 -> oe rises after edge 14, TA bit=0, data 16'h0141, oe falls after edge 31.
// - Write reg 4 = 16'hA5C3, phyad match -> wr_valid_o 1-cycle pulse, wr_addr_o=4, wr_data_o=A5C3; subsequent read of reg 4 returns A5C3.
// - Write with phyad=5'h02 while phy_addr_i=5'h01 -> no wr_valid_o, mdio_oe_o stays 0 whole frame, reg unchanged.
// - 31-bit preamble then read frame -> frame ignored, oe never asserted; next frame with 32x1 served normally.
// - Read reg 31 with NumRegs=16 -> returns 16'hFFFF; write reg 31 -> no wr_valid_o.
// - Assert rst_i at edge 20 of a read -> mdio_oe_o=0, mdio_o=1, busy_o=0 next cycle; following full frame decoded correctly.

Source files
------------

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder: decodes station frames on a synchronised MDC/MDIO
// pair and serves a 16-bit register file with optional write notifications.
module mdio_phy_responder #(
  parameter int unsigned                PreambleLen = 32,
  parameter int unsigned                NumRegs     = 32,
  parameter logic [NumRegs-1:0][15:0]   RegResetVal = '0,
  parameter int unsigned                SyncStages  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  phy_addr_i,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  output logic        busy_o,
  output logic        wr_valid_o,
  output logic [4:0]  wr_addr_o,
  output logic [15:0] wr_data_o
);

  localparam int unsigned AW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  localparam int unsigned PW = $clog2(PreambleLen + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_TA, S_RDATA, S_WDATA, S_SKIP} state_t;

  logic [SyncStages-1:0]      r_mdc_sync;
  logic [SyncStages-1:0]      r_mdio_sync;
  logic                       r_mdc_qq;
  state_t                     r_state;
  logic [4:0]                 r_k;
  logic [PW-1:0]              r_pre;
  logic [14:0]                r_sh;
  logic [15:0]                r_shadow;
  logic [4:0]                 r_regad;
  logic                       r_is_rd;
  logic [NumRegs-1:0][15:0]   r_regs;
  logic                       r_mdio;
  logic                       r_mdio_oe;
  logic                       r_wr_valid;
  logic [4:0]                 r_wr_addr;
  logic [15:0]                r_wr_data;

  logic        w_edge;
  logic        w_bit;
  logic [1:0]  w_op;
  logic [4:0]  w_field;
  logic [15:0] w_wd;
  logic        w_ra_ok;
  logic        w_wr_ok;

  assign w_edge  = r_mdc_sync[SyncStages-1] & ~r_mdc_qq;
  assign w_bit   = r_mdio_sync[SyncStages-1];
  assign w_op    = {r_sh[0], w_bit};
  assign w_field = {r_sh[3:0], w_bit};
  assign w_wd    = {r_sh, w_bit};
  assign w_ra_ok = 32'(w_field) < NumRegs;
  assign w_wr_ok = 32'(r_regad) < NumRegs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mdc_sync  <= '0;
      r_mdio_sync <= '1;
      r_mdc_qq    <= 1'b0;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[SyncStages-2:0], mdc_i};
      r_mdio_sync <= {r_mdio_sync[SyncStages-2:0], mdio_i};
      r_mdc_qq    <= r_mdc_sync[SyncStages-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_pre      <= '0;
      r_sh       <= '0;
      r_shadow   <= '0;
      r_regad    <= '0;
      r_is_rd    <= 1'b0;
      r_regs     <= RegResetVal;
      r_mdio     <= 1'b1;
      r_mdio_oe  <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_edge) begin
        r_k <= r_k + 5'd1;
        case (r_state)
          S_IDLE: begin
            if (w_bit) begin
              if (r_pre != PW'(PreambleLen)) r_pre <= r_pre + PW'(1);
            end else if (r_pre == PW'(PreambleLen)) begin
              // the ST start bit (k=0) is consumed here
              r_state <= S_HDR;
              r_k     <= 5'd1;
              r_pre   <= '0;
            end else begin
              r_pre <= '0;
            end
          end
          S_HDR: begin
            r_sh <= {r_sh[13:0], w_bit};
            if (r_k == 5'd1 && !w_bit) r_state <= S_IDLE;
            if (r_k == 5'd3) begin
              r_is_rd <= (w_op == 2'b10);
              if (w_op == 2'b00 || w_op == 2'b11) r_state <= S_IDLE;
            end
            if (r_k == 5'd8 && w_field != phy_addr_i) r_state <= S_SKIP;
            if (r_k == 5'd13) begin
              r_regad  <= w_field;
              r_shadow <= w_ra_ok ? r_regs[w_field[AW-1:0]] : 16'hFFFF;
              r_state  <= S_TA;
            end
          end
          S_TA: begin
            if (r_k == 5'd14) begin
              if (r_is_rd) begin
                r_mdio_oe <= 1'b1;
                r_mdio    <= 1'b0;
                r_state   <= S_RDATA;
              end
            end else begin
              r_state <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (r_k == 5'd31) begin
              r_mdio_oe <= 1'b0;
              r_mdio    <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_mdio   <= r_shadow[15];
              r_shadow <= {r_shadow[14:0], 1'b0};
            end
          end
          S_WDATA: begin
            r_sh <= {r_sh[13:0], w_bit};
            if (r_k == 5'd31) begin
              if (w_wr_ok) begin
                r_regs[r_regad[AW-1:0]] <= w_wd;
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_regad;
                r_wr_data  <= w_wd;
              end
              r_state <= S_IDLE;
            end
          end
          S_SKIP: begin
            if (r_k == 5'd31) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mdio_o     = r_mdio;
  assign mdio_oe_o  = r_mdio_oe;
  assign busy_o     = (r_state != S_IDLE);
  assign wr_valid_o = r_wr_valid;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: a 32-register and a 16-register instance share
// one station; directed table, hand-written corner sequences, random frames.
module tb_mdio_phy_responder;

  localparam logic [31:0][15:0] RV_A = 512'h0141 << 32;
  localparam logic [15:0][15:0] RV_B = 256'h0141 << 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mdc = 1'b0;
  logic mdio = 1'b1;
  logic [4:0] phy_addr = 5'h01;

  logic o_a, oe_a, bz_a, wv_a;
  logic [4:0] wa_a;
  logic [15:0] wd_a;
  logic o_b, oe_b, bz_b, wv_b;
  logic [4:0] wa_b;
  logic [15:0] wd_b;

  mdio_phy_responder #(.PreambleLen(32), .NumRegs(32), .RegResetVal(RV_A), .SyncStages(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .phy_addr_i(phy_addr), .mdc_i(mdc), .mdio_i(mdio),
    .mdio_o(o_a), .mdio_oe_o(oe_a), .busy_o(bz_a), .wr_valid_o(wv_a),
    .wr_addr_o(wa_a), .wr_data_o(wd_a));

  mdio_phy_responder #(.PreambleLen(32), .NumRegs(16), .RegResetVal(RV_B), .SyncStages(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .phy_addr_i(phy_addr), .mdc_i(mdc), .mdio_i(mdio),
    .mdio_o(o_b), .mdio_oe_o(oe_b), .busy_o(bz_b), .wr_valid_o(wv_b),
    .wr_addr_o(wa_b), .wr_data_o(wd_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  always @(negedge clk) begin
    if (wv_a) pulses_a = pulses_a + 1;
    if (wv_b) pulses_b = pulses_b + 1;
  end

  logic [31:0] s_oe_a, s_o_a, s_bz_a, s_oe_b, s_o_b, s_bz_b;

  // reference state
  logic [15:0] m_a [32];
  logic [15:0] m_b [16];
  logic [4:0]  la_a, la_b;
  logic [15:0] ld_a, ld_b;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_a[i] = (i == 2) ? 16'h0141 : 16'h0000;
    for (int i = 0; i < 16; i++) m_b[i] = (i == 2) ? 16'h0141 : 16'h0000;
    la_a = '0; ld_a = '0; la_b = '0; ld_b = '0;
  endtask

  task automatic send_bit(input logic b, input int k);
    mdc = 1'b0; mdio = b;
    #40;
    mdc = 1'b1;
    #39;
    if (k >= 0) begin
      s_oe_a[k] = oe_a; s_o_a[k] = o_a; s_bz_a[k] = bz_a;
      s_oe_b[k] = oe_b; s_o_b[k] = o_b; s_bz_b[k] = bz_b;
    end
    #1;
  endtask

  task automatic do_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                          input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, input int nbits);
    logic [31:0] fw;
    @(negedge clk);
    if (op == 2'b01) fw = {st, op, pa, ra, 2'b10, wd};
    else             fw = {st, op, pa, ra, 2'b11, 16'hFFFF};
    pulses_a = 0; pulses_b = 0;
    s_oe_a = '0; s_o_a = '0; s_bz_a = '0; s_oe_b = '0; s_o_b = '0; s_bz_b = '0;
    for (int i = 0; i < pre; i++) send_bit(1'b1, -1);
    for (int k = 0; k < nbits; k++) send_bit(fw[31-k], k);
  endtask

  // kind: 0 = ignored, 1 = served read, 2 = served without driving (write or other PHY)
  task automatic check_frame(input string tag, input int d, input int kind,
                             input logic [15:0] rd, input int exp_p,
                             input logic [4:0] la, input logic [15:0] ld);
    logic [31:0] eo, eoe, ebz, go, goe, gbz;
    logic [4:0] ga;
    logic [15:0] gd;
    int gp;
    if (d == 0) begin go = s_o_a; goe = s_oe_a; gbz = s_bz_a; ga = wa_a; gd = wd_a; gp = pulses_a; end
    else        begin go = s_o_b; goe = s_oe_b; gbz = s_bz_b; ga = wa_b; gd = wd_b; gp = pulses_b; end
    eo = '1;
    eoe = '0;
    if (kind == 1) begin
      eoe = 32'h7FFF_C000;
      eo[14] = 1'b0;
      for (int i = 0; i < 16; i++) eo[15+i] = rd[15-i];
    end
    ebz = (kind == 0) ? 32'h0 : 32'h7FFF_FFFF;
    chk($sformatf("%s_d%0d_oe", tag, d), 64'(goe), 64'(eoe));
    chk($sformatf("%s_d%0d_mdio", tag, d), 64'(go), 64'(eo));
    chk($sformatf("%s_d%0d_busy", tag, d), 64'(gbz), 64'(ebz));
    chk($sformatf("%s_d%0d_pulses", tag, d), 64'(gp), 64'(exp_p));
    chk($sformatf("%s_d%0d_wrout", tag, d), 64'({ga, gd}), 64'({la, ld}));
  endtask

  task automatic pulse_reset();
    mdc = 1'b0;
    #20;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int          pre;
    logic        wr;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [15:0] wd;
    int          kind_a;
    int          kind_b;
    logic [15:0] rd_a;
    logic [15:0] rd_b;
    int          p_a;
    int          p_b;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{32, 1'b0, 5'd1, 5'd2,  16'h0000, 1, 1, 16'h0141, 16'h0141, 0, 0};
    tbl[1]  = '{32, 1'b1, 5'd1, 5'd4,  16'hA5C3, 2, 2, 16'h0000, 16'h0000, 1, 1};
    tbl[2]  = '{32, 1'b0, 5'd1, 5'd4,  16'h0000, 1, 1, 16'hA5C3, 16'hA5C3, 0, 0};
    tbl[3]  = '{32, 1'b1, 5'd2, 5'd4,  16'h1234, 2, 2, 16'h0000, 16'h0000, 0, 0};
    tbl[4]  = '{32, 1'b0, 5'd1, 5'd4,  16'h0000, 1, 1, 16'hA5C3, 16'hA5C3, 0, 0};
    tbl[5]  = '{31, 1'b0, 5'd1, 5'd2,  16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[6]  = '{32, 1'b0, 5'd1, 5'd2,  16'h0000, 1, 1, 16'h0141, 16'h0141, 0, 0};
    tbl[7]  = '{32, 1'b0, 5'd1, 5'd31, 16'h0000, 1, 1, 16'h0000, 16'hFFFF, 0, 0};
    tbl[8]  = '{32, 1'b1, 5'd1, 5'd31, 16'hBEEF, 2, 2, 16'h0000, 16'h0000, 1, 0};
    tbl[9]  = '{40, 1'b0, 5'd1, 5'd31, 16'h0000, 1, 1, 16'hBEEF, 16'hFFFF, 0, 0};
    tbl[10] = '{32, 1'b0, 5'd3, 5'd2,  16'h0000, 2, 2, 16'h0000, 16'h0000, 0, 0};

    model_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_a", 64'({oe_a, o_a, bz_a, wv_a, wa_a, wd_a}), 64'({1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0}));
    chk("reset_b", 64'({oe_b, o_b, bz_b, wv_b, wa_b, wd_b}), 64'({1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0}));
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 11; i++) begin
      do_frame(tbl[i].pre, 2'b01, tbl[i].wr ? 2'b01 : 2'b10, tbl[i].pa, tbl[i].ra, tbl[i].wd, 32);
      if (tbl[i].p_a != 0) begin la_a = tbl[i].ra; ld_a = tbl[i].wd; m_a[tbl[i].ra] = tbl[i].wd; end
      if (tbl[i].p_b != 0) begin la_b = tbl[i].ra; ld_b = tbl[i].wd; m_b[tbl[i].ra[3:0]] = tbl[i].wd; end
      check_frame($sformatf("tbl%0d", i), 0, tbl[i].kind_a, tbl[i].rd_a, tbl[i].p_a, la_a, ld_a);
      check_frame($sformatf("tbl%0d", i), 1, tbl[i].kind_b, tbl[i].rd_b, tbl[i].p_b, la_b, ld_b);
    end

    // bad start bit aborts right after k=1
    do_frame(32, 2'b00, 2'b10, 5'd1, 5'd2, 16'h0000, 2);
    chk("bad_st_busy_a", 64'(s_bz_a[1:0]), 64'(2'b01));
    chk("bad_st_busy_b", 64'(s_bz_b[1:0]), 64'(2'b01));

    // reserved opcode aborts right after k=3
    do_frame(32, 2'b01, 2'b11, 5'd1, 5'd2, 16'h0000, 4);
    chk("bad_op_busy_a", 64'(s_bz_a[3:0]), 64'(4'b0111));
    chk("bad_op_oe_a", 64'(s_oe_a), 64'(0));

    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0000, 32);
    check_frame("recover", 0, 1, m_a[4], 0, la_a, ld_a);

    // reset in the middle of a read, after edge 20
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 21);
    chk("midrd_oe_before", 64'({s_oe_a[20], s_oe_b[20]}), 64'(2'b11));
    pulse_reset();
    chk("midrd_rst_a", 64'({oe_a, o_a, bz_a, wv_a, wa_a, wd_a}), 64'({1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0}));
    chk("midrd_rst_b", 64'({oe_b, o_b, bz_b, wv_b, wa_b, wd_b}), 64'({1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0}));
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 32);
    check_frame("after_rst", 0, 1, 16'h0141, 0, la_a, ld_a);
    check_frame("after_rst", 1, 1, 16'h0141, 0, la_b, ld_b);

    // partial write cut by reset leaves the register untouched
    do_frame(32, 2'b01, 2'b01, 5'd1, 5'd5, 16'h1111, 25);
    chk("partial_wr_pulses", 64'(pulses_a + pulses_b), 64'(0));
    pulse_reset();
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd5, 16'h0000, 32);
    check_frame("partial_rd", 0, 1, 16'h0000, 0, la_a, ld_a);

    // random frames against the reference model
    begin
      logic last_short;
      last_short = 1'b0;
      for (int n = 0; n < 40; n++) begin
        int pre, ka, kb, pa_exp, pb_exp;
        logic wr;
        logic [4:0] pa, ra;
        logic [15:0] wd, rda, rdb;
        if (last_short) pre = 32;
        else if ($urandom_range(0, 5) == 0) pre = 31;
        else pre = 32 + $urandom_range(0, 2);
        wr = 1'($urandom_range(0, 1));
        pa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd1;
        ra = 5'($urandom_range(0, 31));
        wd = 16'($urandom);
        rda = 16'h0; rdb = 16'h0; pa_exp = 0; pb_exp = 0;
        if (pre < 32) begin
          ka = 0; kb = 0;
        end else if (pa != phy_addr) begin
          ka = 2; kb = 2;
        end else if (!wr) begin
          ka = 1; kb = 1;
          rda = m_a[ra];
          rdb = (ra < 16) ? m_b[ra[3:0]] : 16'hFFFF;
        end else begin
          ka = 2; kb = 2;
          pa_exp = 1; m_a[ra] = wd; la_a = ra; ld_a = wd;
          if (ra < 16) begin pb_exp = 1; m_b[ra[3:0]] = wd; la_b = ra; ld_b = wd; end
        end
        last_short = (pre < 32);
        do_frame(pre, 2'b01, wr ? 2'b01 : 2'b10, pa, ra, wd, 32);
        check_frame($sformatf("rnd%0d", n), 0, ka, rda, pa_exp, la_a, ld_a);
        check_frame($sformatf("rnd%0d", n), 1, kb, rdb, pb_exp, la_b, ld_b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
